// File: rtl/quad_inc_dec_gen.sv
// Quadrature front-end: synchronizes and glitch-filters qa/qb, then decodes Gray steps into
// registered inc/dec/err pulses. Define QUAD_ERR_CNT_EN to add the saturating err_cnt output.
module quad_inc_dec_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qa,
  input  logic       qb,
  input  logic       en,
  output logic       inc,
  output logic       dec,
  output logic       err
`ifdef QUAD_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic [4:0] WAIT_LAST = 5'(SYNC_STAGES + FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic [1:0]             raw;
  logic [1:0]             filt_q, filt_d;
  logic [1:0][3:0]        cnt_q, cnt_d;
  logic [1:0]             prev_q;
  logic [4:0]             wait_q, wait_d;
  logic                   init_q, init_d;
  logic                   settled;
  logic [2:0]             step_q, step_d;   // {inc, dec, err} decode stage
  logic [2:0]             pulse_q;          // {inc, dec, err} output stage

  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign raw = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (raw[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == FILT_LAST) begin
        filt_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // Init waits out the synchronizer/filter fill so pins already at 11 after reset are absorbed.
  assign settled = (cnt_q == '0) && (raw == filt_q);
  assign wait_d  = (wait_q == WAIT_LAST) ? wait_q : wait_q + 5'd1;
  assign init_d  = init_q | ((wait_q == WAIT_LAST) && settled);

  always_comb begin
    logic [1:0] cur_pos, prev_pos;
    cur_pos  = gray2bin(filt_q);
    prev_pos = gray2bin(prev_q);
    step_d   = '0;
    if (init_q && en) begin
      step_d[2] = (cur_pos == 2'(prev_pos + 2'd1));
      step_d[1] = (prev_pos == 2'(cur_pos + 2'd1));
      step_d[0] = ((filt_q ^ prev_q) == 2'b11);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      wait_q   <= '0;
      init_q   <= 1'b0;
      step_q   <= '0;
      pulse_q  <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], qa};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], qb};
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      prev_q   <= filt_q;
      wait_q   <= wait_d;
      init_q   <= init_d;
      step_q   <= step_d;
      pulse_q  <= step_q & {3{en}};
    end
  end

  assign inc = pulse_q[2];
  assign dec = pulse_q[1];
  assign err = pulse_q[0];

`ifdef QUAD_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (pulse_q[0] && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_quad_inc_dec_gen.sv
// Directed bench for quad_inc_dec_gen at default parameters; err_cnt is checked when
// QUAD_ERR_CNT_EN is defined.
module tb_quad_inc_dec_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       qa, qb, en;
  logic       inc, dec, err;
`ifdef QUAD_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  quad_inc_dec_gen #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .qa     (qa),
    .qb     (qb),
    .en     (en),
    .inc    (inc),
    .dec    (dec),
    .err    (err)
`ifdef QUAD_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive pins on a negedge, then observe `hold` following negedges.
  task automatic run_step(input logic [1:0] p, input int hold,
                          output int ni, output int nd, output int ne,
                          output int lat, output int multi);
    @(negedge clk);
    qa = p[1];
    qb = p[0];
    ni = 0; nd = 0; ne = 0; lat = -1; multi = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (inc) ni++;
      if (dec) nd++;
      if (err) ne++;
      if (lat < 0 && (inc || dec || err)) lat = k;
      if (int'(inc) + int'(dec) + int'(err) > 1) multi++;
    end
  endtask

  task automatic idle_window(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (inc || dec || err) pulses++;
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0; qa = 1'b0; qb = 1'b0; en = 1'b1;
    #1;
    checks++;
    if ({inc, dec, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000", {inc, dec, err});
    end
`ifdef QUAD_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_err_cnt got %0h exp 0", err_cnt);
    end
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_window(20, pulses);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_idle pulses got %0d exp 0", pulses);
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    int ni, nd, ne, lat, multi;
    for (int i = 0; i < 8; i++) begin
      run_step(seq[i], 10, ni, nd, ne, lat, multi);
      checks++;
      if (ni != 1 || nd != 0 || ne != 0 || multi != 0) begin
        errors++;
        $display("FAIL forward_%0d inc/dec/err/multi got %0d/%0d/%0d/%0d exp 1/0/0/0", i, ni, nd, ne, multi);
      end
      checks++;
      if (lat != 6) begin
        errors++;
        $display("FAIL forward_latency_%0d got %0d exp 6", i, lat);
      end
    end
  endtask

  task automatic test_reverse();
    logic [1:0] seq [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    int ni, nd, ne, lat, multi;
    for (int i = 0; i < 8; i++) begin
      run_step(seq[i], 10, ni, nd, ne, lat, multi);
      checks++;
      if (ni != 0 || nd != 1 || ne != 0 || multi != 0 || lat != 6) begin
        errors++;
        $display("FAIL reverse_%0d inc/dec/err/multi/lat got %0d/%0d/%0d/%0d/%0d exp 0/1/0/0/6",
                 i, ni, nd, ne, multi, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [6] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00};
    int         exp_inc [6] = '{1, 0, 1, 1, 0, 0};
    int ni, nd, ne, lat, multi;
    int tot_inc = 0, tot_dec = 0;
    for (int i = 0; i < 6; i++) begin
      run_step(seq[i], 10, ni, nd, ne, lat, multi);
      tot_inc += ni;
      tot_dec += nd;
      checks++;
      if (ni != exp_inc[i] || nd != 1 - exp_inc[i] || ne != 0) begin
        errors++;
        $display("FAIL interleave_%0d inc/dec/err got %0d/%0d/%0d exp %0d/%0d/0",
                 i, ni, nd, ne, exp_inc[i], 1 - exp_inc[i]);
      end
    end
    checks++;
    if (tot_inc != 3 || tot_dec != 3) begin
      errors++;
      $display("FAIL interleave_totals inc/dec got %0d/%0d exp 3/3", tot_inc, tot_dec);
    end
  endtask

  task automatic test_glitch();
    int ni, nd, ne, lat, multi, pulses;
    run_step(2'b01, 10, ni, nd, ne, lat, multi);
    checks++;
    if (ni != 1 || nd != 0 || ne != 0) begin
      errors++;
      $display("FAIL glitch_setup inc/dec/err got %0d/%0d/%0d exp 1/0/0", ni, nd, ne);
    end
    // qa high for FILT_LEN-1 cycles: must be filtered out
    @(negedge clk); qa = 1'b1;
    repeat (2) @(negedge clk);
    qa = 1'b0;
    idle_window(15, pulses);
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL glitch_short pulses got %0d exp 0", pulses);
    end
    // qa high for FILT_LEN cycles: accepted as 01->11, then the fall is a real 11->01
    @(negedge clk); qa = 1'b1;
    repeat (3) @(negedge clk);
    qa = 1'b0;
    ni = 0; nd = 0; ne = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (inc) ni++;
      if (dec) nd++;
      if (err) ne++;
    end
    checks++;
    if (ni != 1 || nd != 1 || ne != 0) begin
      errors++;
      $display("FAIL glitch_min inc/dec/err got %0d/%0d/%0d exp 1/1/0", ni, nd, ne);
    end
    run_step(2'b00, 10, ni, nd, ne, lat, multi);
    checks++;
    if (ni != 0 || nd != 1 || ne != 0) begin
      errors++;
      $display("FAIL glitch_return inc/dec/err got %0d/%0d/%0d exp 0/1/0", ni, nd, ne);
    end
  endtask

  task automatic test_double_step();
    int ni, nd, ne, lat, multi;
    int tot_err, tot_other;
    run_step(2'b11, 8, ni, nd, ne, lat, multi);
    checks++;
    if (ni != 0 || nd != 0 || ne != 1 || lat != 6) begin
      errors++;
      $display("FAIL double_first inc/dec/err/lat got %0d/%0d/%0d/%0d exp 0/0/1/6", ni, nd, ne, lat);
    end
`ifdef QUAD_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'h01) begin
      errors++;
      $display("FAIL double_err_cnt_1 got %0h exp 01", err_cnt);
    end
`endif
    tot_err = ne;
    tot_other = 0;
    for (int i = 1; i < 300; i++) begin
      run_step((i % 2 == 1) ? 2'b00 : 2'b11, 8, ni, nd, ne, lat, multi);
      tot_err += ne;
      tot_other += ni + nd;
    end
    checks++;
    if (tot_err != 300 || tot_other != 0) begin
      errors++;
      $display("FAIL double_300 err/other got %0d/%0d exp 300/0", tot_err, tot_other);
    end
`ifdef QUAD_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL double_err_cnt_sat got %0h exp FF", err_cnt);
    end
`endif
  endtask

  task automatic test_enable();
    logic [1:0] seq [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    int ni, nd, ne, lat, multi;
    int tot = 0;
    @(negedge clk); en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_step(seq[i], 10, ni, nd, ne, lat, multi);
      tot += ni + nd + ne;
    end
    checks++;
    if (tot != 0) begin
      errors++;
      $display("FAIL en_low pulses got %0d exp 0", tot);
    end
    @(negedge clk); en = 1'b1;
    run_step(2'b11, 10, ni, nd, ne, lat, multi);
    checks++;
    if (ni != 1 || nd != 0 || ne != 0 || lat != 6) begin
      errors++;
      $display("FAIL en_reassert inc/dec/err/lat got %0d/%0d/%0d/%0d exp 1/0/0/6", ni, nd, ne, lat);
    end
  endtask

  task automatic test_reset_mid();
    int ni, nd, ne, lat, multi, pulses;
    logic seen = 1'b0;
    @(negedge clk); qa = 1'b1; qb = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (inc) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre_inc got %b exp 1", seen);
    end
    rst_n = 1'b0;
    qa = 1'b1; qb = 1'b1;
    #1;
    checks++;
    if ({inc, dec, err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_outputs got %b exp 000", {inc, dec, err});
    end
`ifdef QUAD_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_err_cnt got %0h exp 0", err_cnt);
    end
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_window(25, pulses);
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_mid_idle_11 pulses got %0d exp 0", pulses);
    end
    run_step(2'b10, 10, ni, nd, ne, lat, multi);
    checks++;
    if (ni != 1 || nd != 0 || ne != 0 || lat != 6) begin
      errors++;
      $display("FAIL rst_mid_step inc/dec/err/lat got %0d/%0d/%0d/%0d exp 1/0/0/6", ni, nd, ne, lat);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_back_to_back();
    test_glitch();
    test_double_step();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
